// File: rtl/can_tx_mailbox_scheduler.sv
// Transmit mailbox scheduler for a CAN controller: holds host frames, arbitrates
// by {id, rtr}, drives the frame transmitter and handles retries and aborts.
module can_tx_mailbox_scheduler #(
  parameter int NUM_MB      = 4,
  parameter int MAX_RETRIES = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mb_wr,
  input  logic [2:0]        mb_sel,
  input  logic [10:0]       mb_id,
  input  logic              mb_rtr,
  input  logic [3:0]        mb_dlc,
  input  logic [63:0]       mb_data,
  input  logic [NUM_MB-1:0] tx_req,
  input  logic [NUM_MB-1:0] abort_req,
  output logic [NUM_MB-1:0] mb_pending,
  output logic [NUM_MB-1:0] mb_done,
  output logic [NUM_MB-1:0] mb_failed,
  output logic              tx_start,
  output logic [10:0]       tx_id,
  output logic              tx_rtr,
  output logic [3:0]        tx_dlc,
  output logic [63:0]       tx_data,
  input  logic              tx_busy,
  input  logic              tx_ack,
  input  logic              tx_arb_lost,
  input  logic              tx_error
);

  localparam int AW = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    if (dlc > 4'd8) begin
      return 4'd8;
    end else begin
      return dlc;
    end
  endfunction

  logic [10:0]       mb_id_r   [NUM_MB];
  logic              mb_rtr_r  [NUM_MB];
  logic [3:0]        mb_dlc_r  [NUM_MB];
  logic [63:0]       mb_data_r [NUM_MB];
  logic [RW-1:0]     retry_r   [NUM_MB];
  logic [RW-1:0]     retry_nxt_s [NUM_MB];

  state_t            state_r;
  logic [AW-1:0]     active_idx_r;
  logic [TW-1:0]     timer_r;
  logic              abort_flag_r;

  logic [NUM_MB-1:0] wr_en_s;
  logic [NUM_MB-1:0] act_vec_s;
  logic [NUM_MB-1:0] pend_nxt_s;
  logic [NUM_MB-1:0] done_nxt_s;
  logic [NUM_MB-1:0] failed_nxt_s;
  logic              win_valid_s;
  logic [AW-1:0]     win_idx_s;
  logic [11:0]       win_key_s;
  logic              take_s;
  logic              in_wait_s;
  logic              in_flight_s;
  logic              timeout_s;
  logic              ev_ack_s;
  logic              ev_err_s;
  logic              ev_arb_s;
  logic              ev_any_s;
  logic              aborted_s;
  logic              sel_abort_s;

  // Write enables: out-of-range selects and pending mailboxes never match.
  always_comb begin
    for (int i = 0; i < NUM_MB; i++) begin
      wr_en_s[i] = mb_wr && (mb_sel == 3'(i)) && !mb_pending[i];
    end
  end

  // Winner: lowest {id, rtr} among pending mailboxes, strict compare keeps the lowest index on ties.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = {AW{1'b0}};
    win_key_s   = {12{1'b1}};
    take_s      = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      take_s      = mb_pending[i] && (!win_valid_s || ({mb_id_r[i], mb_rtr_r[i]} < win_key_s));
      win_idx_s   = take_s ? AW'(i) : win_idx_s;
      win_key_s   = take_s ? {mb_id_r[i], mb_rtr_r[i]} : win_key_s;
      win_valid_s = win_valid_s | take_s;
    end
  end

  // Outcome decode with ack > error (incl. timeout) > arbitration lost.
  always_comb begin
    in_wait_s   = (state_r == ST_WAIT);
    in_flight_s = (state_r == ST_START) || (state_r == ST_WAIT);
    timeout_s   = in_wait_s && !tx_ack && !tx_error && !tx_arb_lost &&
                  (timer_r == TW'(TIMEOUT_CYC - 1));
    ev_ack_s    = in_wait_s && tx_ack;
    ev_err_s    = in_wait_s && !tx_ack && (tx_error || timeout_s);
    ev_arb_s    = in_wait_s && !tx_ack && !tx_error && tx_arb_lost;
    ev_any_s    = ev_ack_s || ev_err_s || ev_arb_s;
    aborted_s   = abort_flag_r || abort_req[active_idx_r];
    sel_abort_s = (state_r == ST_SELECT) && win_valid_s && abort_req[win_idx_s];
    act_vec_s   = in_flight_s ? ({{(NUM_MB-1){1'b0}}, 1'b1} << active_idx_r) : {NUM_MB{1'b0}};
  end

  // Per-mailbox pending / retry bookkeeping and result pulses.
  always_comb begin
    pend_nxt_s   = mb_pending;
    done_nxt_s   = {NUM_MB{1'b0}};
    failed_nxt_s = {NUM_MB{1'b0}};
    for (int i = 0; i < NUM_MB; i++) begin
      retry_nxt_s[i] = retry_r[i];
      if (tx_req[i] && !mb_pending[i]) begin
        pend_nxt_s[i]  = 1'b1;
        retry_nxt_s[i] = {RW{1'b0}};
      end else if (abort_req[i] && mb_pending[i] && !act_vec_s[i]) begin
        pend_nxt_s[i]   = 1'b0;
        failed_nxt_s[i] = 1'b1;
        retry_nxt_s[i]  = {RW{1'b0}};
      end else if (act_vec_s[i] && ev_any_s) begin
        if (ev_ack_s) begin
          pend_nxt_s[i]  = 1'b0;
          done_nxt_s[i]  = 1'b1;
          retry_nxt_s[i] = {RW{1'b0}};
        end else if (aborted_s) begin
          // An aborted frame that did not complete fails without consuming a retry.
          pend_nxt_s[i]   = 1'b0;
          failed_nxt_s[i] = 1'b1;
          retry_nxt_s[i]  = {RW{1'b0}};
        end else if (ev_err_s) begin
          if (retry_r[i] == RW'(MAX_RETRIES - 1)) begin
            pend_nxt_s[i]   = 1'b0;
            failed_nxt_s[i] = 1'b1;
            retry_nxt_s[i]  = {RW{1'b0}};
          end else begin
            retry_nxt_s[i] = retry_r[i] + RW'(1);
          end
        end else begin
          retry_nxt_s[i] = retry_r[i];
        end
      end else begin
        retry_nxt_s[i] = retry_r[i];
      end
    end
  end

  // Mailbox storage, loaded by accepted host writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_MB; i++) begin
        mb_id_r[i]   <= 11'd0;
        mb_rtr_r[i]  <= 1'b0;
        mb_dlc_r[i]  <= 4'd0;
        mb_data_r[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < NUM_MB; i++) begin
        if (wr_en_s[i]) begin
          mb_id_r[i]   <= mb_id;
          mb_rtr_r[i]  <= mb_rtr;
          mb_dlc_r[i]  <= clamp_dlc(mb_dlc);
          mb_data_r[i] <= mb_data;
        end
      end
    end
  end

  // Pending flags, retry counters and result pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mb_pending <= {NUM_MB{1'b0}};
      mb_done    <= {NUM_MB{1'b0}};
      mb_failed  <= {NUM_MB{1'b0}};
      for (int i = 0; i < NUM_MB; i++) begin
        retry_r[i] <= {RW{1'b0}};
      end
    end else begin
      mb_pending <= pend_nxt_s;
      mb_done    <= done_nxt_s;
      mb_failed  <= failed_nxt_s;
      for (int i = 0; i < NUM_MB; i++) begin
        retry_r[i] <= retry_nxt_s[i];
      end
    end
  end

  // Transmit sequencer: IDLE -> SELECT -> START -> WAIT -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      active_idx_r <= {AW{1'b0}};
      timer_r      <= {TW{1'b0}};
      abort_flag_r <= 1'b0;
      tx_start     <= 1'b0;
      tx_id        <= 11'd0;
      tx_rtr       <= 1'b0;
      tx_dlc       <= 4'd0;
      tx_data      <= 64'd0;
    end else begin
      tx_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          abort_flag_r <= 1'b0;
          timer_r      <= {TW{1'b0}};
          if ((|mb_pending) && !tx_busy) begin
            state_r <= ST_SELECT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SELECT: begin
          // A winner aborted in this very cycle is dropped without starting.
          if (win_valid_s && !sel_abort_s) begin
            active_idx_r <= win_idx_s;
            tx_id        <= mb_id_r[win_idx_s];
            tx_rtr       <= mb_rtr_r[win_idx_s];
            tx_dlc       <= mb_dlc_r[win_idx_s];
            tx_data      <= mb_data_r[win_idx_s];
            tx_start     <= 1'b1;
            state_r      <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          timer_r      <= {TW{1'b0}};
          abort_flag_r <= abort_flag_r | abort_req[active_idx_r];
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ev_any_s) begin
            abort_flag_r <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            timer_r      <= timer_r + TW'(1);
            abort_flag_r <= abort_flag_r | abort_req[active_idx_r];
            state_r      <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_mailbox_scheduler.sv
// Scoreboard bench: a queue-based arbitration model predicts every start frame
// and every done/failed pulse; a monitor compares, a responder plays the transmitter.
module tb_can_tx_mailbox_scheduler;

  localparam int NUM_MB      = 4;
  localparam int MAX_RETRIES = 4;
  localparam int TIMEOUT_CYC = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mb_wr = 1'b0;
  logic [2:0]        mb_sel = 3'd0;
  logic [10:0]       mb_id = 11'd0;
  logic              mb_rtr = 1'b0;
  logic [3:0]        mb_dlc = 4'd0;
  logic [63:0]       mb_data = 64'd0;
  logic [NUM_MB-1:0] tx_req = '0;
  logic [NUM_MB-1:0] stim_abort = '0;
  logic [NUM_MB-1:0] resp_abort = '0;
  logic [NUM_MB-1:0] abort_req;
  logic [NUM_MB-1:0] mb_pending, mb_done, mb_failed;
  logic              tx_start, tx_rtr;
  logic [10:0]       tx_id;
  logic [3:0]        tx_dlc;
  logic [63:0]       tx_data;
  logic              tx_busy = 1'b0;
  logic              tx_ack = 1'b0;
  logic              tx_arb_lost = 1'b0;
  logic              tx_error = 1'b0;

  assign abort_req = stim_abort | resp_abort;

  can_tx_mailbox_scheduler #(
    .NUM_MB(NUM_MB), .MAX_RETRIES(MAX_RETRIES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst_n), .mb_wr(mb_wr), .mb_sel(mb_sel), .mb_id(mb_id),
    .mb_rtr(mb_rtr), .mb_dlc(mb_dlc), .mb_data(mb_data), .tx_req(tx_req),
    .abort_req(abort_req), .mb_pending(mb_pending), .mb_done(mb_done),
    .mb_failed(mb_failed), .tx_start(tx_start), .tx_id(tx_id), .tx_rtr(tx_rtr),
    .tx_dlc(tx_dlc), .tx_data(tx_data), .tx_busy(tx_busy), .tx_ack(tx_ack),
    .tx_arb_lost(tx_arb_lost), .tx_error(tx_error)
  );

  // kind: 0 ack, 1 error, 2 arbitration lost, 3 no answer (timeout)
  typedef struct { int idx; logic [10:0] id; logic rtr; logic [3:0] dlc; logic [63:0] data; } frame_t;
  typedef struct { int idx; int kind; bit abort; logic [10:0] id; } plan_t;
  typedef struct { int kind; int idx; } ev_t;   // kind 0 done, 1 failed

  frame_t exp_start_q[$];
  plan_t  plan_q[$];
  plan_t  dir_q[$];
  ev_t    ev_q[$];
  int     start_cyc_q[$];

  logic [10:0]       m_id   [NUM_MB];
  logic              m_rtr  [NUM_MB];
  logic [3:0]        m_dlc  [NUM_MB];
  logic [63:0]       m_data [NUM_MB];
  int                m_retry[NUM_MB];
  logic [NUM_MB-1:0] m_pend = '0;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit resp_en = 1'b1;
  frame_t mon_f;
  ev_t    mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [NUM_MB-1:0] onehot(input int i);
    logic [NUM_MB-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick_winner();
    int best;
    best = -1;
    for (int i = 0; i < NUM_MB; i++)
      if (m_pend[i] && (best < 0 || {m_id[i], m_rtr[i]} < {m_id[best], m_rtr[best]})) best = i;
    return best;
  endfunction

  // Monitor: compare every start frame and result pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        start_cyc_q.push_back(cyc);
        check("start_expected", 128'(exp_start_q.size() != 0), 128'd1);
        if (exp_start_q.size() != 0) begin
          mon_f = exp_start_q.pop_front();
          check("start_frame", {tx_id, tx_rtr, tx_dlc, tx_data},
                {mon_f.id, mon_f.rtr, mon_f.dlc, mon_f.data});
        end
      end
      if (mb_done != '0) begin
        check("done_expected", 128'(ev_q.size() != 0), 128'd1);
        if (ev_q.size() != 0) begin
          mon_e = ev_q.pop_front();
          check("mb_done", mb_done, (mon_e.kind == 0) ? onehot(mon_e.idx) : '0);
        end
      end
      if (mb_failed != '0) begin
        check("failed_expected", 128'(ev_q.size() != 0), 128'd1);
        if (ev_q.size() != 0) begin
          mon_e = ev_q.pop_front();
          check("mb_failed", mb_failed, (mon_e.kind == 1) ? onehot(mon_e.idx) : '0);
        end
      end
    end
  end

  // Responder: answers each started frame according to the planned outcome.
  initial begin
    plan_t p;
    forever begin
      @(negedge clk);
      if (rst_n && resp_en && tx_start && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        repeat ($urandom_range(1, 4)) @(negedge clk);
        if (p.abort) begin
          resp_abort = onehot(p.idx);
          @(negedge clk);
          resp_abort = '0;
        end
        check("tx_id_stable", tx_id, p.id);
        tx_ack      = (p.kind == 0);
        tx_error    = (p.kind == 1);
        tx_arb_lost = (p.kind == 2);
        @(negedge clk);
        tx_ack = 1'b0; tx_error = 1'b0; tx_arb_lost = 1'b0;
      end
    end
  end

  task automatic drive(input logic wr, input logic [2:0] sel, input logic [10:0] id,
                       input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                       input logic [NUM_MB-1:0] req);
    mb_wr = wr; mb_sel = sel; mb_id = id; mb_rtr = rtr; mb_dlc = dlc; mb_data = data; tx_req = req;
    if (wr && int'(sel) < NUM_MB && !m_pend[sel]) begin
      m_id[sel] = id; m_rtr[sel] = rtr; m_data[sel] = data;
      m_dlc[sel] = (dlc > 4'd8) ? 4'd8 : dlc;
    end
    for (int i = 0; i < NUM_MB; i++)
      if (req[i] && !m_pend[i]) begin m_pend[i] = 1'b1; m_retry[i] = 0; end
    @(negedge clk);
    mb_wr = 1'b0; tx_req = '0;
  endtask

  task automatic plan_dir(input int kind, input bit abort);
    plan_t p;
    p.idx = 0; p.kind = kind; p.abort = abort; p.id = 11'd0;
    dir_q.push_back(p);
  endtask

  // Model: replay arbitration over the pending set until every mailbox resolves.
  task automatic plan_round();
    int w, n, r;
    plan_t p;
    n = 0;
    while (m_pend != '0) begin
      w = pick_winner();
      if (dir_q.size() != 0) p = dir_q.pop_front();
      else begin
        r = $urandom_range(0, 99);
        p.kind = (r < 60) ? 0 : (r < 85) ? 1 : 2;
        p.abort = ($urandom_range(0, 9) == 0);
      end
      if (n >= 40) p.kind = 0;
      p.idx = w; p.id = m_id[w];
      exp_start_q.push_back('{w, m_id[w], m_rtr[w], m_dlc[w], m_data[w]});
      plan_q.push_back(p);
      if (p.kind == 0) begin
        ev_q.push_back('{0, w}); m_pend[w] = 1'b0; m_retry[w] = 0;
      end else if (p.abort) begin
        ev_q.push_back('{1, w}); m_pend[w] = 1'b0; m_retry[w] = 0;
      end else if (p.kind != 2) begin
        m_retry[w]++;
        if (m_retry[w] >= MAX_RETRIES) begin
          ev_q.push_back('{1, w}); m_pend[w] = 1'b0; m_retry[w] = 0;
        end
      end
      n++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && (exp_start_q.size() != 0 || plan_q.size() != 0 ||
                          ev_q.size() != 0 || mb_pending != '0)) begin
      @(negedge clk);
      n++;
    end
    check("round_complete", 128'(n < budget), 128'd1);
    repeat (4) @(negedge clk);
    check("pending_clear", mb_pending, '0);
  endtask

  task automatic rand_round();
    logic [NUM_MB-1:0] mask;
    logic [10:0] id;
    int last;
    mask = NUM_MB'($urandom_range(1, (1 << NUM_MB) - 1));
    last = 0;
    for (int i = 0; i < NUM_MB; i++) if (mask[i]) last = i;
    for (int i = 0; i < NUM_MB; i++) begin
      if (mask[i]) begin
        id = ($urandom_range(0, 1) == 1) ? 11'(11'h100 + $urandom_range(0, 2)) : 11'($urandom);
        drive(1'b1, 3'(i), id, 1'($urandom), 4'($urandom), {$urandom, $urandom},
              (i == last) ? mask : '0);
      end
    end
    plan_round();
    wait_idle(3000);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!tx_start && n < 20) begin @(negedge clk); n++; end
    check(name, 128'(tx_start), 128'd1);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < NUM_MB; i++) m_retry[i] = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {mb_pending, mb_done, mb_failed, tx_start, tx_id, tx_rtr, tx_dlc, tx_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {mb_pending, mb_done, mb_failed, tx_start}, '0);

    // Priority by id, then latency and in-order completion.
    drive(1'b1, 3'd0, 11'h123, 1'b0, 4'd8, 64'h0102030405060708, '0);
    start_cyc_q.delete();
    c0 = cyc;
    drive(1'b1, 3'd2, 11'h0A0, 1'b0, 4'd12, 64'hA0A1A2A3A4A5A6A7, 4'b0101);
    check("pending_set", mb_pending, 4'b0101);
    plan_dir(0, 1'b0); plan_dir(0, 1'b0);
    plan_round();
    wait_idle(500);
    check("start_latency", 128'(start_cyc_q[0] - c0), 128'd3);

    // Data frame beats remote frame with the same id; equal keys go to the lower index.
    drive(1'b1, 3'd0, 11'h200, 1'b1, 4'd2, 64'h1111, '0);
    drive(1'b1, 3'd1, 11'h200, 1'b0, 4'd3, 64'h2222, 4'b0011);
    plan_round();
    wait_idle(500);
    drive(1'b1, 3'd3, 11'h300, 1'b0, 4'd1, 64'h3333, '0);
    drive(1'b1, 3'd1, 11'h300, 1'b0, 4'd1, 64'h4444, 4'b1010);
    plan_round();
    wait_idle(500);

    // Errors until retries are exhausted.
    start_cyc_q.delete();
    drive(1'b1, 3'd1, 11'h055, 1'b0, 4'd4, 64'hDEAD, 4'b0010);
    for (int i = 0; i < MAX_RETRIES; i++) plan_dir(1, 1'b0);
    plan_round();
    wait_idle(1000);
    check("error_start_count", 128'(start_cyc_q.size()), 128'(MAX_RETRIES));

    // Lost arbitration ten times never fails the frame.
    start_cyc_q.delete();
    drive(1'b1, 3'd3, 11'h456, 1'b1, 4'd0, 64'h0, 4'b1000);
    for (int i = 0; i < 10; i++) plan_dir(2, 1'b0);
    plan_dir(0, 1'b0);
    plan_round();
    wait_idle(1000);
    check("arb_start_count", 128'(start_cyc_q.size()), 128'd11);

    // Abort of the active frame: error -> failed without retry; ack -> done.
    start_cyc_q.delete();
    drive(1'b1, 3'd2, 11'h600, 1'b0, 4'd5, 64'h5555, 4'b0100);
    plan_dir(1, 1'b1);
    plan_round();
    wait_idle(500);
    check("abort_err_starts", 128'(start_cyc_q.size()), 128'd1);
    drive(1'b0, 3'd0, 11'h0, 1'b0, 4'd0, 64'h0, 4'b0100);
    plan_dir(0, 1'b1);
    plan_round();
    wait_idle(500);

    // Idle-state abort, and writes ignored while pending or out of range.
    tx_busy = 1'b1;
    start_cyc_q.delete();
    drive(1'b1, 3'd1, 11'h077, 1'b0, 4'd6, 64'h7777, 4'b0010);
    repeat (3) @(negedge clk);
    check("busy_holds_idle", {28'(start_cyc_q.size()), mb_pending}, {28'd0, 4'b0010});
    drive(1'b1, 3'd1, 11'h7FF, 1'b1, 4'd1, 64'hFFFF, '0);
    drive(1'b1, 3'd6, 11'h001, 1'b0, 4'd1, 64'h1, '0);
    stim_abort = 4'b0010;
    ev_q.push_back('{1, 1}); m_pend[1] = 1'b0;
    @(negedge clk);
    stim_abort = '0;
    repeat (3) @(negedge clk);
    check("idle_abort_clear", mb_pending, '0);
    tx_busy = 1'b0;
    drive(1'b0, 3'd0, 11'h0, 1'b0, 4'd0, 64'h0, 4'b0010);
    plan_dir(0, 1'b0);
    plan_round();
    wait_idle(500);

    // No answer: timeout counts as an error and the frame is retried.
    start_cyc_q.delete();
    drive(1'b1, 3'd0, 11'h321, 1'b0, 4'd7, 64'h9999, 4'b0001);
    plan_dir(3, 1'b0); plan_dir(0, 1'b0);
    plan_round();
    wait_idle(TIMEOUT_CYC + 500);
    check("timeout_gap", 128'(start_cyc_q[1] - start_cyc_q[0]), 128'(TIMEOUT_CYC + 3));

    for (int r = 0; r < 40; r++) rand_round();

    // Reset in START (tx_start drops asynchronously) and in WAIT.
    resp_en = 1'b0;
    drive(1'b1, 3'd0, 11'h111, 1'b0, 4'd1, 64'hAB, 4'b0001);
    exp_start_q.push_back('{0, m_id[0], m_rtr[0], m_dlc[0], m_data[0]});
    m_pend = '0;
    wait_start("rst_start_seen");
    #2 rst_n = 1'b0;
    #1 check("async_rst_start", {mb_pending, tx_start}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd2, 11'h222, 1'b1, 4'd2, 64'hCD, 4'b0100);
    exp_start_q.push_back('{2, m_id[2], m_rtr[2], m_dlc[2], m_data[2]});
    m_pend = '0;
    wait_start("rst_wait_start_seen");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_in_wait", {mb_pending, mb_done, mb_failed, tx_start, tx_id, tx_rtr, tx_dlc, tx_data}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_quiet", {mb_pending, tx_start}, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
